// File: rtl/cpu_pkg.sv
// Shared fetch-control types: FSM states, redirect sources, the bundled
// pipeline inputs and the aligned-target adder.
package cpu_pkg;

  localparam int unsigned RISCV_INSN_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    RS_NONE   = 2'd0,
    RS_BOOT   = 2'd1,
    RS_FRONT  = 2'd2,
    RS_COMMIT = 2'd3
  } redirect_src_e;

  typedef struct packed {
    logic        iq_full;
    logic        fe_valid;
    logic [31:0] fe_pc;
    logic [31:0] fe_imm;
    logic        fe_pred_taken;
    logic        cm_valid;
    logic        cm_is_jump;
    logic        cm_pred_taken;
    logic        cm_taken;
    logic [31:0] cm_pc;
    logic [31:0] cm_imm;
  } pipe_in_t;

  // Modulo-2^32 add with the two low bits cleared (instructions are word aligned).
  function automatic logic [31:0] align_target(input logic [31:0] base,
                                               input logic [31:0] offset);
    logic [31:0] sum;
    sum = base + offset;
    return {sum[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_stats.sv
// Saturating event counters for branches, mispredicts and front-end redirects.
// Only instantiated when FETCH_REDIRECT_STATS_EN is defined.
module fetch_redirect_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_evt_i,
  input  logic        mispredict_evt_i,
  input  logic        front_evt_i,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispredicts_o,
  output logic [31:0] stat_front_redirects_o
);

  logic [31:0] branches_q, mispredicts_q, front_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic evt);
    if (evt && (cnt != 32'hFFFF_FFFF)) begin
      return cnt + 32'd1;
    end else begin
      return cnt;
    end
  endfunction

  // Count each event, holding at all-ones once saturated.
  always_ff @(posedge clk) begin
    if (!reset) begin
      branches_q    <= 32'd0;
      mispredicts_q <= 32'd0;
      front_q       <= 32'd0;
    end else begin
      branches_q    <= sat_inc(branches_q, branch_evt_i);
      mispredicts_q <= sat_inc(mispredicts_q, mispredict_evt_i);
      front_q       <= sat_inc(front_q, front_evt_i);
    end
  end

  assign stat_branches_o        = branches_q;
  assign stat_mispredicts_o     = mispredicts_q;
  assign stat_front_redirects_o = front_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage sequencer: chooses the next-PC source (commit mispredict >
// front-end taken > sequential), emits PC load / flush pulses, gates fetch,
// and forwards predictor training writes. All outputs are registered.
// Optional macro FETCH_REDIRECT_STATS_EN adds saturating event counters.
module fetch_redirect_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iq_full,
  input  logic        fe_valid,
  input  logic [31:0] fe_pc,
  input  logic [31:0] fe_imm,
  input  logic        fe_pred_taken,
  input  logic        cm_valid,
  input  logic        cm_is_jump,
  input  logic        cm_pred_taken,
  input  logic        cm_taken,
  input  logic [31:0] cm_pc,
  input  logic [31:0] cm_imm,
  output logic        pc_load,
  output logic [31:0] pc_update,
  output logic        fetch_enable,
  output logic        flush_front,
  output logic        flush_back,
  output logic        bp_upd_valid,
  output logic        bp_upd_value,
  output logic [31:0] bp_upd_pc
`ifdef FETCH_REDIRECT_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
  output logic [31:0] stat_front_redirects
`endif
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);

  pipe_in_t      in_s;
  redirect_src_e src_s;
  logic          branch_s, mispredict_s, front_s;

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_load_q, pc_load_d;
  logic [31:0]      pc_update_q, pc_update_d;
  logic             fetch_enable_q, fetch_enable_d;
  logic             flush_front_q, flush_front_d;
  logic             flush_back_q, flush_back_d;
  logic             bp_valid_q, bp_valid_d;
  logic             bp_value_q, bp_value_d;
  logic [31:0]      bp_pc_q, bp_pc_d;

  // Bundle the pipeline-facing inputs.
  always_comb begin
    in_s               = '0;
    in_s.iq_full       = iq_full;
    in_s.fe_valid      = fe_valid;
    in_s.fe_pc         = fe_pc;
    in_s.fe_imm        = fe_imm;
    in_s.fe_pred_taken = fe_pred_taken;
    in_s.cm_valid      = cm_valid;
    in_s.cm_is_jump    = cm_is_jump;
    in_s.cm_pred_taken = cm_pred_taken;
    in_s.cm_taken      = cm_taken;
    in_s.cm_pc         = cm_pc;
    in_s.cm_imm        = cm_imm;
  end

  // A front redirect is only honoured while fetch is actively running.
  assign branch_s     = in_s.cm_valid & ~in_s.cm_is_jump;
  assign mispredict_s = branch_s & (in_s.cm_pred_taken != in_s.cm_taken) & (state_q != BOOT);
  assign front_s      = in_s.fe_valid & in_s.fe_pred_taken & fetch_enable_q &
                        (state_q == RUN) & ~in_s.iq_full & ~mispredict_s;

  // Redirect source selection in priority order.
  always_comb begin
    src_s = RS_NONE;
    if (state_q == BOOT) begin
      src_s = RS_BOOT;
    end else if (mispredict_s) begin
      src_s = RS_COMMIT;
    end else if (front_s) begin
      src_s = RS_FRONT;
    end else begin
      src_s = RS_NONE;
    end
  end

  // Next-state, flush counter and next output values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_load_d     = 1'b0;
    pc_update_d   = pc_update_q;
    flush_front_d = 1'b0;
    flush_back_d  = 1'b0;
    bp_valid_d    = branch_s;
    bp_value_d    = in_s.cm_taken;
    bp_pc_d       = in_s.cm_pc;

    case (state_q)
      BOOT:  state_d = RUN;
      RUN:   state_d = in_s.iq_full ? STALL : RUN;
      STALL: state_d = in_s.iq_full ? STALL : RUN;
      FLUSH: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = in_s.iq_full ? STALL : RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = BOOT;
    endcase

    case (src_s)
      RS_BOOT: begin
        pc_load_d   = 1'b1;
        pc_update_d = RESET_PC;
      end
      RS_COMMIT: begin
        pc_load_d     = 1'b1;
        flush_front_d = 1'b1;
        flush_back_d  = 1'b1;
        pc_update_d   = in_s.cm_taken ? align_target(in_s.cm_pc, in_s.cm_imm)
                                      : align_target(in_s.cm_pc, 32'(RISCV_INSN_BYTES));
        state_d       = FLUSH;
        cnt_d         = FLUSH_INIT;
      end
      RS_FRONT: begin
        pc_load_d     = 1'b1;
        flush_front_d = 1'b1;
        pc_update_d   = align_target(in_s.fe_pc, in_s.fe_imm);
      end
      default: pc_load_d = 1'b0;
    endcase

    // Fetch runs in the cycle after we land in RUN, except straight out of BOOT.
    fetch_enable_d = (state_d == RUN) && (state_q != BOOT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= BOOT;
      cnt_q          <= {CNT_W{1'b0}};
      pc_load_q      <= 1'b0;
      pc_update_q    <= RESET_PC;
      fetch_enable_q <= 1'b0;
      flush_front_q  <= 1'b0;
      flush_back_q   <= 1'b0;
      bp_valid_q     <= 1'b0;
      bp_value_q     <= 1'b0;
      bp_pc_q        <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pc_load_q      <= pc_load_d;
      pc_update_q    <= pc_update_d;
      fetch_enable_q <= fetch_enable_d;
      flush_front_q  <= flush_front_d;
      flush_back_q   <= flush_back_d;
      bp_valid_q     <= bp_valid_d;
      bp_value_q     <= bp_value_d;
      bp_pc_q        <= bp_pc_d;
    end
  end

  assign pc_load      = pc_load_q;
  assign pc_update    = pc_update_q;
  assign fetch_enable = fetch_enable_q;
  assign flush_front  = flush_front_q;
  assign flush_back   = flush_back_q;
  assign bp_upd_valid = bp_valid_q;
  assign bp_upd_value = bp_value_q;
  assign bp_upd_pc    = bp_pc_q;

`ifdef FETCH_REDIRECT_STATS_EN
  fetch_redirect_stats u_stats (
    .clk                    (clk),
    .reset                  (reset),
    .branch_evt_i           (branch_s),
    .mispredict_evt_i       (mispredict_s),
    .front_evt_i            (front_s),
    .stat_branches_o        (stat_branches),
    .stat_mispredicts_o     (stat_mispredicts),
    .stat_front_redirects_o (stat_front_redirects)
  );
`endif

endmodule
